// File: rtl/controle_esteira.sv
// Conveyor sequencing FSM: moves, fills and caps one bottle at a time, counts dozens.
// Optional bottle-sensor debounce filter enabled by defining DEBOUNCE_EN.
module controle_esteira #(
    parameter int MAX_DUZIAS      = 9,
    parameter int FILL_TIMEOUT    = 1000,
    parameter int SEAL_CYCLES     = 50,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       sensor_garrafa,
    input  logic       sensor_nivel,
    input  logic [3:0] duzias,
    output logic       motor_on,
    output logic       valvula_on,
    output logic       vedacao_on,
    output logic       inc_duzia,
    output logic [3:0] garrafas,
    output logic       lote_cheio,
    output logic       alarme
);

    typedef enum logic [2:0] {IDLE, MOVE, FILL, SEAL, FULL, ERRO} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  garrafa_sync_reg, nivel_sync_reg;
    logic        garrafa_prev_reg;
    logic        garrafa_filt;
    logic        bottle_event;
    logic        nivel;
    logic [15:0] timer_reg, timer_next;
    logic        stop_pend_reg, stop_pend_next;
    logic [3:0]  garrafas_reg, garrafas_next;
    logic        inc_next;
    logic        motor_reg, valvula_reg, vedacao_reg, inc_reg, lote_reg, alarme_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            garrafa_sync_reg <= 2'b00;
            nivel_sync_reg   <= 2'b00;
            garrafa_prev_reg <= 1'b0;
        end else begin
            garrafa_sync_reg <= {garrafa_sync_reg[0], sensor_garrafa};
            nivel_sync_reg   <= {nivel_sync_reg[0], sensor_nivel};
            garrafa_prev_reg <= garrafa_filt;
        end
    end

`ifdef DEBOUNCE_EN
    logic        filt_reg;
    logic [15:0] deb_cnt_reg;

    // The filtered value flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_reg    <= 1'b0;
            deb_cnt_reg <= 16'd0;
        end else if (garrafa_sync_reg[1] == filt_reg) begin
            deb_cnt_reg <= 16'd0;
        end else if (deb_cnt_reg == 16'(DEBOUNCE_CYCLES - 1)) begin
            filt_reg    <= garrafa_sync_reg[1];
            deb_cnt_reg <= 16'd0;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + 16'd1;
        end
    end

    assign garrafa_filt = filt_reg;
`else
    assign garrafa_filt = garrafa_sync_reg[1];
`endif

    assign bottle_event = garrafa_filt & ~garrafa_prev_reg;
    assign nivel        = nivel_sync_reg[1];

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        stop_pend_next = stop_pend_reg;
        garrafas_next  = garrafas_reg;
        inc_next       = 1'b0;
        case (state_reg)
            IDLE: if (start && !stop) state_next = MOVE;
            MOVE: begin
                if (stop)              state_next = IDLE;
                else if (bottle_event) state_next = FILL;
            end
            FILL: begin
                if (stop) stop_pend_next = 1'b1;
                if (nivel)                                    state_next = SEAL;
                else if (timer_reg == 16'(FILL_TIMEOUT - 1)) state_next = ERRO;
            end
            SEAL: begin
                if (stop) stop_pend_next = 1'b1;
                if (timer_reg == 16'(SEAL_CYCLES - 1)) begin
                    if (garrafas_reg == 4'd11) begin
                        garrafas_next = 4'd0;
                        inc_next      = 1'b1;
                    end else begin
                        garrafas_next = garrafas_reg + 4'd1;
                    end
                    if (garrafas_reg == 4'd11 && duzias == 4'(MAX_DUZIAS)) state_next = FULL;
                    else if (stop_pend_reg || stop)                         state_next = IDLE;
                    else                                                    state_next = MOVE;
                end
            end
            FULL, ERRO: if (start && !stop) state_next = MOVE;
            default: state_next = IDLE;
        endcase
        // The timer restarts on every state change and only runs in FILL and SEAL.
        if (state_next != state_reg)                   timer_next = 16'd0;
        else if (state_reg == FILL || state_reg == SEAL) timer_next = timer_reg + 16'd1;
        else                                             timer_next = 16'd0;
        if (state_next == IDLE) stop_pend_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            timer_reg     <= 16'd0;
            stop_pend_reg <= 1'b0;
            garrafas_reg  <= 4'd0;
            motor_reg     <= 1'b0;
            valvula_reg   <= 1'b0;
            vedacao_reg   <= 1'b0;
            inc_reg       <= 1'b0;
            lote_reg      <= 1'b0;
            alarme_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            stop_pend_reg <= stop_pend_next;
            garrafas_reg  <= garrafas_next;
            motor_reg     <= (state_next == MOVE);
            valvula_reg   <= (state_next == FILL);
            vedacao_reg   <= (state_next == SEAL);
            inc_reg       <= inc_next;
            lote_reg      <= (state_next == FULL);
            alarme_reg    <= (state_next == ERRO);
        end
    end

    assign motor_on   = motor_reg;
    assign valvula_on = valvula_reg;
    assign vedacao_on = vedacao_reg;
    assign inc_duzia  = inc_reg;
    assign garrafas   = garrafas_reg;
    assign lote_cheio = lote_reg;
    assign alarme     = alarme_reg;

endmodule

// File: tb/tb_controle_esteira.sv
// Self-checking bench for controle_esteira: vector table plus bottle-cycle scoreboard.
// Define DEBOUNCE_EN on both files to exercise the debounce filter.
module tb_controle_esteira;

    localparam int TIMEOUT = 20;
    localparam int SEAL    = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0;
    logic       sensor_garrafa = 1'b0, sensor_nivel = 1'b0;
    logic [3:0] duzias = 4'd0;
    logic       motor_on, valvula_on, vedacao_on, inc_duzia, lote_cheio, alarme;
    logic [3:0] garrafas;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    controle_esteira #(
        .MAX_DUZIAS(9), .FILL_TIMEOUT(TIMEOUT), .SEAL_CYCLES(SEAL), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sensor_garrafa(sensor_garrafa), .sensor_nivel(sensor_nivel), .duzias(duzias),
        .motor_on(motor_on), .valvula_on(valvula_on), .vedacao_on(vedacao_on),
        .inc_duzia(inc_duzia), .garrafas(garrafas), .lote_cheio(lote_cheio), .alarme(alarme)
    );

    typedef struct {
        logic       rst, st, sp, g, n;
        logic [9:0] exp;
    } vec_t;

    typedef struct packed {
        logic [3:0] g;
        logic       inc, motor, lote;
    } seal_exp_t;

    logic [9:0] sb_vec[$];
    seal_exp_t  sb_seal[$];

    function automatic logic [9:0] ex(bit m, bit v, bit s, bit i, logic [3:0] g, bit l, bit a);
        return {m, v, s, i, g, l, a};
    endfunction

    function automatic logic [9:0] obs();
        return {motor_on, valvula_on, vedacao_on, inc_duzia, garrafas, lote_cheio, alarme};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; sensor_garrafa = 1'b0; sensor_nivel = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    // One full bottle: wait for FILL, raise nivel, time the SEAL, then compare the outcome.
    task automatic bottle(input bit stop_mid, input logic [3:0] eg, input bit ei,
                          input bit em, input bit el);
        int n;
        int c;
        seal_exp_t e;
        sb_seal.push_back('{g: eg, inc: ei, motor: em, lote: el});
        sensor_garrafa = 1'b0;
        repeat (12) step();
        sensor_garrafa = 1'b1;
        n = 0;
        while (!valvula_on && n < 60) begin step(); n++; end
        check("fill_latency", n, LAT);
        sensor_garrafa = 1'b0;
        if (stop_mid) begin stop = 1'b1; step(); stop = 1'b0; end
        sensor_nivel = 1'b1;
        n = 0;
        while (!vedacao_on && n < 60) begin step(); n++; end
        check("seal_entry", vedacao_on, 1);
        sensor_nivel = 1'b0;
        c = 0;
        while (vedacao_on && c < 60) begin c++; step(); end
        check("seal_len", c, SEAL);
        e = sb_seal.pop_front();
        check("garrafas", garrafas, e.g);
        check("inc_duzia", inc_duzia, e.inc);
        check("motor_after", motor_on, e.motor);
        check("lote_cheio", lote_cheio, e.lote);
        step();
        check("inc_width", inc_duzia, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[22];
        int n;
        int c;
        int hit;

`ifndef DEBOUNCE_EN
        vecs[0]  = '{1, 0, 0, 0, 0, ex(0, 0, 0, 0, 4'd0, 0, 0)};
        vecs[1]  = '{0, 1, 0, 0, 0, ex(1, 0, 0, 0, 4'd0, 0, 0)};
        vecs[2]  = '{0, 0, 0, 1, 0, ex(1, 0, 0, 0, 4'd0, 0, 0)};
        vecs[3]  = '{0, 0, 0, 1, 0, ex(1, 0, 0, 0, 4'd0, 0, 0)};
        vecs[4]  = '{0, 0, 0, 1, 0, ex(0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[5]  = '{0, 0, 0, 0, 0, ex(0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[6]  = '{0, 0, 0, 0, 0, ex(0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[7]  = '{0, 0, 0, 0, 1, ex(0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[8]  = '{0, 0, 0, 0, 1, ex(0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[9]  = '{0, 0, 0, 0, 1, ex(0, 0, 1, 0, 4'd0, 0, 0)};
        vecs[10] = '{0, 0, 0, 0, 0, ex(0, 0, 1, 0, 4'd0, 0, 0)};
        vecs[11] = '{0, 0, 0, 0, 0, ex(0, 0, 1, 0, 4'd0, 0, 0)};
        vecs[12] = '{0, 0, 0, 0, 0, ex(0, 0, 1, 0, 4'd0, 0, 0)};
        vecs[13] = '{0, 0, 0, 0, 0, ex(1, 0, 0, 0, 4'd1, 0, 0)};
        vecs[14] = '{0, 0, 0, 1, 0, ex(1, 0, 0, 0, 4'd1, 0, 0)};
        vecs[15] = '{0, 0, 0, 1, 0, ex(1, 0, 0, 0, 4'd1, 0, 0)};
        vecs[16] = '{0, 0, 1, 1, 0, ex(0, 0, 0, 0, 4'd1, 0, 0)};
        vecs[17] = '{0, 0, 0, 1, 0, ex(0, 0, 0, 0, 4'd1, 0, 0)};
        vecs[18] = '{0, 1, 1, 1, 0, ex(0, 0, 0, 0, 4'd1, 0, 0)};
        vecs[19] = '{0, 1, 0, 1, 0, ex(1, 0, 0, 0, 4'd1, 0, 0)};
        vecs[20] = '{0, 0, 0, 1, 0, ex(1, 0, 0, 0, 4'd1, 0, 0)};
        vecs[21] = '{0, 0, 0, 0, 0, ex(1, 0, 0, 0, 4'd1, 0, 0)};

        for (int i = 0; i < 22; i++) begin
            logic [9:0] e;
            reset = vecs[i].rst; start = vecs[i].st; stop = vecs[i].sp;
            sensor_garrafa = vecs[i].g; sensor_nivel = vecs[i].n;
            sb_vec.push_back(vecs[i].exp);
            step();
            e = sb_vec.pop_front();
            check($sformatf("vec%0d", i), obs(), e);
        end
`else
        do_reset();
        check("reset_outputs", obs(), 0);
        start = 1'b1; step(); start = 1'b0;
        sensor_garrafa = 1'b1;
        repeat (5) step();
        sensor_garrafa = 1'b0;
        hit = 0;
        for (int i = 0; i < 20; i++) begin step(); if (valvula_on) hit++; end
        check("glitch_no_fill", hit, 0);
        check("glitch_motor", motor_on, 1);
        sensor_garrafa = 1'b1;
        n = 0;
        while (!valvula_on && n < 60) begin step(); n++; end
        check("debounce_latency", n, LAT);
        step();
        sensor_garrafa = 1'b0;
`endif

        // Dozen completes without ending the batch.
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        duzias = 4'd3;
        for (int i = 0; i < 12; i++)
            bottle(0, (i == 11) ? 4'd0 : 4'(i + 1), i == 11, 1, 0);

        // Dozen completes at MAX_DUZIAS: batch full.
        duzias = 4'd9;
        for (int i = 0; i < 12; i++)
            bottle(0, (i == 11) ? 4'd0 : 4'(i + 1), i == 11, i != 11, i == 11);
        check("full_hold_lote", lote_cheio, 1);
        check("full_motor_off", motor_on, 0);
        start = 1'b1; step(); start = 1'b0;
        check("full_restart_motor", motor_on, 1);
        check("full_restart_lote", lote_cheio, 0);

        // Fill timeout.
        duzias = 4'd0;
        bottle(0, 4'd1, 0, 1, 0);
        bottle(0, 4'd2, 0, 1, 0);
        repeat (12) step();
        sensor_garrafa = 1'b1;
        n = 0;
        while (!valvula_on && n < 60) begin step(); n++; end
        sensor_garrafa = 1'b0;
        c = 0;
        while (valvula_on && c < 100) begin c++; step(); end
        check("fill_cycles", c, TIMEOUT);
        check("erro_alarme", alarme, 1);
        check("erro_garrafas", garrafas, 2);
        check("erro_motor", motor_on, 0);
        step();
        check("erro_hold", alarme, 1);
        start = 1'b1; step(); start = 1'b0;
        check("erro_restart_motor", motor_on, 1);
        check("erro_restart_alarme", alarme, 0);

        // Stop during FILL finishes the bottle, then idles; stop request is cleared after.
        bottle(1, 4'd3, 0, 0, 0);
        check("stop_idle_motor", motor_on, 0);
        check("stop_idle_valve", valvula_on, 0);
        start = 1'b1; step(); start = 1'b0;
        check("stop_restart", motor_on, 1);
        bottle(0, 4'd4, 0, 1, 0);

        // Reset in the middle of SEAL.
        repeat (12) step();
        sensor_garrafa = 1'b1;
        n = 0;
        while (!valvula_on && n < 60) begin step(); n++; end
        sensor_garrafa = 1'b0;
        sensor_nivel = 1'b1;
        n = 0;
        while (!vedacao_on && n < 60) begin step(); n++; end
        sensor_nivel = 1'b0;
        step();
        check("pre_reset_seal", vedacao_on, 1);
        reset = 1'b1; step();
        check("reset_mid_seal", obs(), 0);
        reset = 1'b0; step();
        check("reset_stays_idle", obs(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
